// File: rtl/sec_timer_sched.sv
// sec_timer_sched: multi-channel seconds-timeout scheduler sharing one tick chain.
//
// Each of NCH requesters loads a timeout in whole seconds via a req/ack
// handshake. Loads are granted round-robin, one per cycle. Running channels
// count down on one_sec pulses and emit a one-cycle done pulse on expiry.
// tick_en is high (from a register) whenever any channel is running.
//
// Parameters:
//   NCH - number of requester channels (2..8)
//   CW  - seconds-count width per channel
//
// Ports:
//   clk      - clock
//   rst      - synchronous, active-low reset
//   one_sec  - one-cycle one-second pulse from the tick chain
//   tick_en  - enable to the tick chain (OR of busy, registered)
//   req      - per-channel load request (level)
//   req_secs - per-channel timeout; channel i at [i*CW +: CW]
//   cancel   - per-channel abort, sampled each cycle
//   ack      - one-cycle load-accepted pulse
//   busy     - channel running
//   done     - one-cycle expiry pulse
//
// Build option:
//   SEC_SCHED_AUTORELOAD_EN - when defined, each channel captures its timeout
//   at grant and reloads it on expiry, staying busy until cancel or reset.

module sec_timer_sched #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              one_sec,
    output logic              tick_en,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*CW-1:0] req_secs,
    input  logic [NCH-1:0]    cancel,
    output logic [NCH-1:0]    ack,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    done
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {StIdle, StRun} ch_state_e;

    ch_state_e      st_q  [NCH];
    ch_state_e      st_d  [NCH];
    logic [CW-1:0]  rem_q [NCH];
    logic [CW-1:0]  rem_d [NCH];
`ifdef SEC_SCHED_AUTORELOAD_EN
    logic [CW-1:0]  rld_q [NCH];
    logic [CW-1:0]  rld_d [NCH];
`endif
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [NCH-1:0] ack_q, ack_d;
    logic [NCH-1:0] done_q, done_d;
    logic [NCH-1:0] run_d;
    logic           tick_en_q, tick_en_d;

    logic [NCH-1:0] elig;
    logic           gnt_vld;
    logic [PW-1:0]  gnt_idx;

    // A channel may be granted only while idle; requests from running
    // channels are ignored until they return to idle.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            elig[i] = req[i] && (st_q[i] == StIdle);
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int unsigned   idx;
        logic [PW-1:0] cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx  = (32'(ptr_q) + k) % NCH;
            cand = PW'(idx);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        ptr_d = gnt_vld ? gnt_idx : ptr_q;
    end

    // Per-channel next state.
    always_comb begin
        logic [CW-1:0] secs;
        secs = '0;
        for (int i = 0; i < NCH; i++) begin
            st_d[i]   = st_q[i];
            rem_d[i]  = rem_q[i];
`ifdef SEC_SCHED_AUTORELOAD_EN
            rld_d[i]  = rld_q[i];
`endif
            ack_d[i]  = 1'b0;
            done_d[i] = 1'b0;
            secs      = req_secs[i*CW +: CW];

            if (st_q[i] == StIdle) begin
                // cancel on an idle channel is ignored and never blocks a grant
                if (gnt_vld && (gnt_idx == PW'(i))) begin
                    ack_d[i] = 1'b1;
                    rem_d[i] = secs;
`ifdef SEC_SCHED_AUTORELOAD_EN
                    rld_d[i] = secs;
`endif
                    if (secs != '0) begin
                        st_d[i] = StRun;
                    end else begin
                        // zero-length: acked and expired at once, never runs
                        done_d[i] = 1'b1;
                    end
                end
            end else begin
                if (cancel[i]) begin
                    // cancel beats a coincident expiry
                    st_d[i] = StIdle;
                end else if (one_sec) begin
                    rem_d[i] = rem_q[i] - CW'(1);
                    if (rem_q[i] == CW'(1)) begin
                        done_d[i] = 1'b1;
`ifdef SEC_SCHED_AUTORELOAD_EN
                        rem_d[i]  = rld_q[i];
`else
                        st_d[i]   = StIdle;
`endif
                    end
                end
            end
            run_d[i] = (st_d[i] == StRun);
        end
    end

    // Registered so tick_en tracks busy with no combinational path from inputs.
    always_comb begin
        tick_en_d = |run_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i]  <= StIdle;
                rem_q[i] <= '0;
`ifdef SEC_SCHED_AUTORELOAD_EN
                rld_q[i] <= '0;
`endif
            end
            ptr_q     <= PW'(NCH - 1);
            ack_q     <= '0;
            done_q    <= '0;
            tick_en_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i]  <= st_d[i];
                rem_q[i] <= rem_d[i];
`ifdef SEC_SCHED_AUTORELOAD_EN
                rld_q[i] <= rld_d[i];
`endif
            end
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            tick_en_q <= tick_en_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            busy[i] = (st_q[i] == StRun);
        end
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign tick_en = tick_en_q;

endmodule

// File: doc/sec_timer_sched.md
# sec_timer_sched

Multi-channel seconds-timeout scheduler that shares the single 100 ms/1 s tick chain between NCH requesters. Each requester loads a timeout in whole seconds through a req/ack handshake. The block gates the tick chain's enable while any channel is running, counts one-second pulses per channel, and returns a one-cycle done pulse on expiry. Channel loads are granted round-robin, one per cycle, through a single write port into the shared remaining-count table.

## Interface
Parameters:
- NCH, 4, number of requester channels (2..8)
- CW, 8, seconds-count width per channel

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- one_sec  in  1  one-cycle one-second pulse from the tick chain
- tick_en  out  1  enable to the tick chain
- req  in  NCH  per-channel load request, level
- req_secs  in  NCH*CW  timeout value; channel i occupies bits [i*CW +: CW]
- cancel  in  NCH  per-channel abort, sampled each cycle
- ack  out  NCH  one-cycle load-accepted pulse
- busy  out  NCH  channel running
- done  out  NCH  one-cycle expiry pulse

## Operation
- Per-channel state machine:
  - IDLE → RUN on grant when req_secs != 0.
  - RUN → IDLE on expiry, with done pulsed.
  - RUN → IDLE on cancel, with no done.
- Eligibility: a channel is eligible when req=1 and busy=0.
- Arbiter: exactly one eligible channel is granted per cycle. Search is round-robin, starting at the channel after the last grant. The pointer resets to NCH-1, so channel 0 has first priority after reset.
- On grant: remaining[i] ← req_secs[i]. Zero-length requests are still acked.
- Decrement: remaining[i] decrements by 1 on each one_sec while busy[i]=1.
  - When remaining[i]==1 and one_sec=1, the channel expires.
  - Counts are unsigned CW bits. No wrap is possible because 0 is never loaded into RUN.
- Zero-length request: ack and done pulse together. busy stays 0. tick_en is unaffected.
- Requester protocol: hold req until ack, then drop req the cycle after ack. If req is still high after done, the request is treated as a new one.
- Simultaneous events:
  - cancel on the cycle the channel expires: cancel wins, no done.
  - cancel on a non-busy channel: ignored. cancel does not block a grant in the same cycle.
  - one_sec in the grant cycle: does not decrement the newly loaded channel. Other busy channels decrement normally.
  - req from a busy channel: not eligible, no ack.
- tick_en = OR of busy, driven from registers. It drops the cycle after the last channel expires or is cancelled.

## Timing
- Reset values: ack=0, done=0, busy=0, tick_en=0, all remaining=0, pointer=NCH-1.
- Reset mid-operation: all channels return to IDLE next edge; no done is issued.
- Load: req sampled high at edge t (granted) → ack=1 and busy=1 after edge t; tick_en=1 after the same edge.
- Expiry: one_sec sampled at edge t with remaining==1 → done=1 and busy=0 after edge t.
- Cancel: sampled at edge t → busy=0 after edge t.
- Under contention, the worst-case wait for a grant is NCH-1 cycles.

## Configuration
- SEC_SCHED_AUTORELOAD_EN defined:
  - Each channel keeps a reload register captured at grant.
  - On expiry the channel pulses done, reloads remaining from the register, and stays busy.
  - Only cancel or rst returns it to IDLE.
  - Zero-length requests behave as in the default build.
- Undefined: one-shot behaviour as described under Operation; no reload registers are built.

## Test plan
- Single shot: reset, then req[0] with secs=3, then three one_sec pulses 100 cycles apart → ack[0] one cycle after req; busy[0]=1; done[0] exactly one cycle after the third pulse; tick_en falls the same cycle.
- Contention: req on channels 0, 1 and 2 in the same cycle, each with secs=2 → acks on channels 0, 1, 2 on consecutive cycles; a second burst on channels 2 and 3 then grants channel 3 first.
- Zero length: req[1] with secs=0 → ack[1] and done[1] in the same cycle; busy[1] and tick_en stay 0.
- Cancel race: channel 2 loaded with secs=1; cancel[2] and one_sec asserted together → no done[2]; busy[2]=0.
- Grant-cycle tick: one_sec in the grant cycle of channel 0 with secs=2 → done only after two further pulses.
- Reset mid-run and autoreload:
  - Default build: rst low while two channels are busy → all outputs 0 next cycle; no done.
  - With SEC_SCHED_AUTORELOAD_EN: secs=2 → done every second one_sec pulse until cancel.
